// File: rtl/icache_sa_pkg.sv
// icache_sa_pkg
// Shared definitions for the set-associative instruction cache:
//   - refill FSM state encoding (IDLE / REFILL)
//   - helper functions that derive address-field widths from the cache parameters
// Optional build switch (defined on the tool command line, not here):
//   ICACHE_CRIT_WORD_FIRST_EN  - critical-word-first refill with early restart.
//                                When undefined the line fills sequentially from
//                                word 0 and nothing hits while a refill is running.
package icache_sa_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_REFILL = 1'b1
    } state_e;

    // Byte offset inside a 32-bit word; always ignored for fetches.
    localparam int BYTE_OFF_W = 2;

    // Width of the tag field: everything between the set index and ADDR_W.
    function automatic int tag_w(input int addr_w, input int sets_log2, input int line_words_log2);
        return addr_w - sets_log2 - line_words_log2 - BYTE_OFF_W;
    endfunction

    // Bit position of the tag field's LSB inside a byte address.
    function automatic int tag_lsb(input int sets_log2, input int line_words_log2);
        return sets_log2 + line_words_log2 + BYTE_OFF_W;
    endfunction

endpackage

// File: rtl/icache_way.sv
// icache_way
// Storage for one way of the instruction cache: per-set valid bit and tag, and
// a line of 32-bit words per set. Provides a combinational lookup port and a
// write side used by the refill engine in the top level.
// Ports:
//   clk, rst       clock, asynchronous active-low reset (clears valid bits)
//   clr_all_i      invalidate every set on the next edge
//   rd_idx_i/rd_off_i/rd_tag_i   lookup set, word and tag
//   hit_o, valid_o, rd_data_o    lookup results (rd_data_o is unqualified)
//   alloc_i        claim set rd_idx_i: clear its valid bit and store rd_tag_i
//   wr_en_i/wr_idx_i/wr_off_i/wr_data_i   refill word write
//   fill_done_i    mark set wr_idx_i valid once its line is complete
module icache_way
    import icache_sa_pkg::*;
#(
    parameter int SETS_LOG2       = 5,
    parameter int LINE_WORDS_LOG2 = 2,
    parameter int TAG_W           = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr_all_i,
    input  logic [SETS_LOG2-1:0]       rd_idx_i,
    input  logic [LINE_WORDS_LOG2-1:0] rd_off_i,
    input  logic [TAG_W-1:0]           rd_tag_i,
    output logic                       hit_o,
    output logic                       valid_o,
    output logic [31:0]                rd_data_o,
    input  logic                       alloc_i,
    input  logic                       wr_en_i,
    input  logic [SETS_LOG2-1:0]       wr_idx_i,
    input  logic [LINE_WORDS_LOG2-1:0] wr_off_i,
    input  logic [31:0]                wr_data_i,
    input  logic                       fill_done_i
);

    localparam int SETS  = 1 << SETS_LOG2;
    localparam int WORDS = 1 << (SETS_LOG2 + LINE_WORDS_LOG2);

    logic [SETS-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0] tag_mem  [SETS];
    logic [31:0]      data_mem [WORDS];

    // Allocation drops the valid bit so a half-filled line can never hit;
    // a global clear wins over everything else.
    always_comb begin
        valid_d = valid_q;
        if (clr_all_i) begin
            valid_d = '0;
        end else begin
            if (alloc_i)     valid_d[rd_idx_i] = 1'b0;
            if (fill_done_i) valid_d[wr_idx_i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) valid_q <= '0;
        else      valid_q <= valid_d;
    end

    // Tag and data are plain RAM-style storage; only valid needs a reset.
    always_ff @(posedge clk) begin
        if (alloc_i) tag_mem[rd_idx_i] <= rd_tag_i;
        if (wr_en_i) data_mem[{wr_idx_i, wr_off_i}] <= wr_data_i;
    end

    assign valid_o   = valid_q[rd_idx_i];
    assign hit_o     = valid_o && (tag_mem[rd_idx_i] == rd_tag_i);
    assign rd_data_o = data_mem[{rd_idx_i, rd_off_i}];

endmodule

// File: rtl/icache_sa.sv
// icache_sa
// Set-associative instruction cache with multi-word lines, LRU replacement,
// flush (fence.i) and an autonomous word-by-word refill engine.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   rdy                 global ready; 0 freezes all state and ignores acks
//   flush_i             invalidate everything and abort any refill
//   req_i, addr_i       fetch request and byte address
//   hit_o, inst_o       combinational hit and instruction (0 on miss)
//   mem_req_o/mem_addr_o   registered refill request and word address
//   mem_ack_i/mem_data_i   one refill word per acknowledged cycle
// Optional build switch: ICACHE_CRIT_WORD_FIRST_EN (critical word first with
// early restart during the refill).
module icache_sa
    import icache_sa_pkg::*;
#(
    parameter int ADDR_W          = 17,
    parameter int SETS_LOG2       = 5,
    parameter int LINE_WORDS_LOG2 = 2,
    parameter int WAYS            = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        flush_i,
    input  logic        req_i,
    input  logic [31:0] addr_i,
    output logic        hit_o,
    output logic [31:0] inst_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i
);

    localparam int OFF_W   = LINE_WORDS_LOG2;
    localparam int IDX_W   = SETS_LOG2;
    localparam int TAG_W   = tag_w(ADDR_W, SETS_LOG2, LINE_WORDS_LOG2);
    localparam int TAG_LSB = tag_lsb(SETS_LOG2, LINE_WORDS_LOG2);
    localparam int LINE_W  = 32 - OFF_W - BYTE_OFF_W;
    localparam int SETS    = 1 << SETS_LOG2;

    logic [OFF_W-1:0] req_off;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             unused_byte_off;

    assign req_off         = addr_i[OFF_W+1:2];
    assign req_idx         = addr_i[TAG_LSB-1:OFF_W+2];
    assign req_tag         = addr_i[ADDR_W-1:TAG_LSB];
    assign unused_byte_off = ^addr_i[1:0];

    state_e            state_q, state_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [OFF_W-1:0]  count_q, count_d;
    logic [OFF_W-1:0]  start_q, start_d;
    logic              victim_q, victim_d;
    logic              mem_req_q, mem_req_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [SETS-1:0]   lru_q, lru_d;

    logic [WAYS-1:0] way_hit, way_valid, way_alloc, way_wr, way_done;
    logic [31:0]     way_data [WAYS];

    logic             hit_any, hit_way, victim_sel;
    logic [31:0]      hit_data;
    logic             flush_go, miss_go, ack_go, last_ack, hit_idle;
    logic [OFF_W-1:0] fill_off, start_new;
    logic [IDX_W-1:0] line_idx;

    // The line register holds addr[31:OFF_W+2], so the set index is its low bits.
    assign line_idx = line_q[IDX_W-1:0];
    assign fill_off = start_q + count_q;

`ifdef ICACHE_CRIT_WORD_FIRST_EN
    assign start_new = req_off;
`else
    assign start_new = '0;
`endif

    assign flush_go = rdy && flush_i;
    assign hit_idle = rdy && req_i && (state_q == ST_IDLE) && hit_any;
    assign miss_go  = rdy && req_i && !flush_i && (state_q == ST_IDLE) && !hit_any;
    assign ack_go   = rdy && !flush_i && (state_q == ST_REFILL) && mem_ack_i;
    assign last_ack = ack_go && (count_q == '1);

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        assign way_alloc[w] = miss_go  && (victim_sel == 1'(w));
        assign way_wr[w]    = ack_go   && (victim_q   == 1'(w));
        assign way_done[w]  = last_ack && (victim_q   == 1'(w));

        icache_way #(
            .SETS_LOG2       (SETS_LOG2),
            .LINE_WORDS_LOG2 (LINE_WORDS_LOG2),
            .TAG_W           (TAG_W)
        ) u_way (
            .clk         (clk),
            .rst         (rst),
            .clr_all_i   (flush_go),
            .rd_idx_i    (req_idx),
            .rd_off_i    (req_off),
            .rd_tag_i    (req_tag),
            .hit_o       (way_hit[w]),
            .valid_o     (way_valid[w]),
            .rd_data_o   (way_data[w]),
            .alloc_i     (way_alloc[w]),
            .wr_en_i     (way_wr[w]),
            .wr_idx_i    (line_idx),
            .wr_off_i    (fill_off),
            .wr_data_i   (mem_data_i),
            .fill_done_i (way_done[w])
        );
    end

    // Way mux and victim choice: the descending loop lets the lowest invalid
    // way win; with every way valid the set's LRU bit names the victim.
    always_comb begin
        hit_any    = |way_hit;
        hit_way    = 1'b0;
        hit_data   = '0;
        victim_sel = (WAYS > 1) ? lru_q[req_idx] : 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (way_hit[w]) begin
                hit_way  = 1'(w);
                hit_data = way_data[w];
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!way_valid[w]) victim_sel = 1'(w);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // FSM next state; flush beats both a new miss and the last refill word.
    always_comb begin
        state_d = state_q;
        if (flush_go) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   if (miss_go)  state_d = ST_REFILL;
                ST_REFILL: if (last_ack) state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Refill bookkeeping and LRU. mem_addr always points at the next word
    // to fetch, wrapping inside the line.
    always_comb begin
        line_d     = line_q;
        count_d    = count_q;
        start_d    = start_q;
        victim_d   = victim_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        lru_d      = lru_q;
        if (flush_go) begin
            mem_req_d = 1'b0;
            lru_d     = '0;
            count_d   = '0;
        end else if (miss_go) begin
            line_d     = addr_i[31:OFF_W+2];
            start_d    = start_new;
            victim_d   = victim_sel;
            count_d    = '0;
            mem_req_d  = 1'b1;
            mem_addr_d = {addr_i[31:OFF_W+2], start_new, 2'b00};
        end else if (ack_go) begin
            count_d    = count_q + 1'b1;
            mem_addr_d = {line_q, fill_off + 1'b1, 2'b00};
            if (last_ack) begin
                mem_req_d = 1'b0;
                if (WAYS > 1) lru_d[line_idx] = ~victim_q;
            end
        end else if (hit_idle && (WAYS > 1)) begin
            lru_d[req_idx] = ~hit_way;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_q     <= '0;
            count_q    <= '0;
            start_q    <= '0;
            victim_q   <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            lru_q      <= '0;
        end else begin
            line_q     <= line_d;
            count_q    <= count_d;
            start_q    <= start_d;
            victim_q   <= victim_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            lru_q      <= lru_d;
        end
    end

    assign mem_req_o  = mem_req_q;
    assign mem_addr_o = mem_addr_q;

`ifdef ICACHE_CRIT_WORD_FIRST_EN
    // Early restart: words of the refilling line are returned once written,
    // and the word arriving this cycle is bypassed straight from memory.
    logic             line_match, early_hit;
    logic [OFF_W-1:0] rel_off;
    logic [31:0]      victim_data, early_data;

    assign line_match = (addr_i[ADDR_W-1:OFF_W+2] == line_q[ADDR_W-OFF_W-3:0]);
    assign rel_off    = req_off - start_q;

    always_comb begin
        victim_data = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (victim_q == 1'(w)) victim_data = way_data[w];
        end
        early_hit  = 1'b0;
        early_data = victim_data;
        if (rdy && req_i && !flush_i && (state_q == ST_REFILL) && line_match) begin
            if (rel_off < count_q) begin
                early_hit = 1'b1;
            end else if ((rel_off == count_q) && mem_ack_i) begin
                early_hit  = 1'b1;
                early_data = mem_data_i;
            end
        end
    end
`endif

    // Hit path output; everything reads as zero on a miss.
    always_comb begin
        hit_o  = 1'b0;
        inst_o = '0;
        if (hit_idle) begin
            hit_o  = 1'b1;
            inst_o = hit_data;
        end
`ifdef ICACHE_CRIT_WORD_FIRST_EN
        else if (early_hit) begin
            hit_o  = 1'b1;
            inst_o = early_data;
        end
`endif
    end

endmodule
